// File: rtl/rpc2_ctrl_cmd_arb_pkg.sv
// Shared definitions for the RPC2 command arbiter.
//   arb_state_t : arbiter FSM states
//   grant_t     : encoding of the most recently granted direction
//   cnt_width() : width of an outstanding-transaction counter for a given limit
package rpc2_ctrl_cmd_arb_pkg;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_ISSUE = 2'd2
   } arb_state_t;

   typedef enum logic {
      GRANT_RD = 1'b0,
      GRANT_WR = 1'b1
   } grant_t;

   function automatic int cnt_width(input int max_outst);
      return $clog2(max_outst + 1);
   endfunction

endpackage

// File: rtl/rpc2_ctrl_outst_cnt.sv
// Outstanding-transaction counter for one direction.
//   clk, rst_n : clock, async active-low reset
//   inc        : a transaction was granted this cycle
//   dec        : a transaction completed this cycle
//   at_max     : count has reached MAX_OUTST (direction must not be granted)
//   underflow  : sticky, set when dec arrives with the count at 0
module rpc2_ctrl_outst_cnt
   import rpc2_ctrl_cmd_arb_pkg::*;
#(
   parameter int MAX_OUTST = 8,
   parameter int CNT_W     = cnt_width(MAX_OUTST)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic at_max,
   output logic underflow
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_OUTST);

   logic [CNT_W-1:0] cnt;

   // inc is only ever asserted below LIMIT, so the count never wraps upward.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         underflow <= 1'b0;
      end else begin
         if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
         end else if (dec && !inc) begin
            if (cnt == '0) begin
               underflow <= 1'b1;
            end else begin
               cnt <= cnt - CNT_W'(1);
            end
         end
      end
   end

   assign at_max = (cnt >= LIMIT);

endmodule

// File: rtl/rpc2_ctrl_cmd_arb.sv
// Arbitrates AXI AR/AW requests onto the single RPC2 engine command port and
// pushes each granted ID into the matching read/write ID FIFO.
//   ar_* / aw_*          : AXI read / write address requests (ready is combinational)
//   cmd_*                : command to the transaction engine (valid/ready)
//   rid_wr_en, wid_wr_en : one-cycle pushes into the external ID FIFOs
//   id_wr_data           : ID being pushed (shared by both FIFOs)
//   rid/wid_pre_full     : FIFO pre_full, registered here into the full flag
//   rd_done, wr_done     : completion pulses that retire outstanding transactions
//   cnt_err              : sticky, a done pulse arrived with its counter at 0
//
// state    | meaning
// ST_INIT  | one cycle after reset release, no grants
// ST_IDLE  | arbitrate; a grant latches the command and pushes the ID
// ST_ISSUE | cmd_valid held with stable fields until cmd_ready
module rpc2_ctrl_cmd_arb
   import rpc2_ctrl_cmd_arb_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 8,
   parameter int MAX_OUTST  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ar_valid,
   output logic                  ar_ready,
   input  logic [ID_WIDTH-1:0]   ar_id,
   input  logic [ADDR_WIDTH-1:0] ar_addr,
   input  logic [LEN_WIDTH-1:0]  ar_len,
   input  logic                  aw_valid,
   output logic                  aw_ready,
   input  logic [ID_WIDTH-1:0]   aw_id,
   input  logic [ADDR_WIDTH-1:0] aw_addr,
   input  logic [LEN_WIDTH-1:0]  aw_len,
   output logic                  cmd_valid,
   input  logic                  cmd_ready,
   output logic                  cmd_write,
   output logic [ADDR_WIDTH-1:0] cmd_addr,
   output logic [LEN_WIDTH-1:0]  cmd_len,
   output logic                  rid_wr_en,
   output logic                  wid_wr_en,
   output logic [ID_WIDTH-1:0]   id_wr_data,
   input  logic                  rid_pre_full,
   input  logic                  wid_pre_full,
   input  logic                  rd_done,
   input  logic                  wr_done,
   output logic                  cnt_err
);

   arb_state_t state_q, state_d;
   grant_t     last_grant_q;
   logic       rfull_q, wfull_q;
   logic       rd_elig, wr_elig;
   logic       grant_rd, grant_wr;
   logic       rd_at_max, wr_at_max;
   logic       rd_uf, wr_uf;

   rpc2_ctrl_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_rd_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (grant_rd),
      .dec       (rd_done),
      .at_max    (rd_at_max),
      .underflow (rd_uf)
   );

   rpc2_ctrl_outst_cnt #(.MAX_OUTST(MAX_OUTST)) u_wr_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (grant_wr),
      .dec       (wr_done),
      .at_max    (wr_at_max),
      .underflow (wr_uf)
   );

   // pre_full registered here equals the FIFO's registered full; grants are at
   // least two cycles apart so this flag already reflects the previous push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         last_grant_q <= GRANT_WR;
         rfull_q      <= 1'b0;
         wfull_q      <= 1'b0;
         cmd_write    <= 1'b0;
         cmd_addr     <= '0;
         cmd_len      <= '0;
      end else begin
         state_q <= state_d;
         rfull_q <= rid_pre_full;
         wfull_q <= wid_pre_full;
         if (grant_rd || grant_wr) begin
            cmd_write    <= grant_wr;
            cmd_addr     <= grant_wr ? aw_addr : ar_addr;
            cmd_len      <= grant_wr ? aw_len  : ar_len;
            last_grant_q <= grant_wr ? GRANT_WR : GRANT_RD;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rd_elig  = 1'b0;
      wr_elig  = 1'b0;
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            rd_elig = ar_valid & ~rfull_q & ~rd_at_max;
            wr_elig = aw_valid & ~wfull_q & ~wr_at_max;
            if (rd_elig && wr_elig) begin
               grant_rd = (last_grant_q == GRANT_WR);
               grant_wr = (last_grant_q == GRANT_RD);
            end else begin
               grant_rd = rd_elig;
               grant_wr = wr_elig;
            end
            if (grant_rd || grant_wr) state_d = ST_ISSUE;
         end
         ST_ISSUE: if (cmd_ready) state_d = ST_IDLE;
         default:  state_d = ST_INIT;
      endcase
   end

   assign ar_ready   = grant_rd;
   assign aw_ready   = grant_wr;
   assign rid_wr_en  = grant_rd;
   assign wid_wr_en  = grant_wr;
   assign id_wr_data = grant_wr ? aw_id : (grant_rd ? ar_id : '0);
   assign cmd_valid  = (state_q == ST_ISSUE);
   assign cnt_err    = rd_uf | wr_uf;

endmodule

// File: tb/tb_rpc2_ctrl_cmd_arb.sv
// Directed bench for rpc2_ctrl_cmd_arb (MAX_OUTST=2). Expected grants are queued
// as stimulus is driven; a negedge monitor pops them on each FIFO push and again
// on each command handshake.
module tb_rpc2_ctrl_cmd_arb;

   localparam int IDW  = 4;
   localparam int AW   = 32;
   localparam int LW   = 8;
   localparam int MAXO = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ar_valid, aw_valid, cmd_ready;
   logic          ar_ready, aw_ready, cmd_valid, cmd_write;
   logic [IDW-1:0] ar_id, aw_id, id_wr_data;
   logic [AW-1:0]  ar_addr, aw_addr, cmd_addr;
   logic [LW-1:0]  ar_len, aw_len, cmd_len;
   logic          rid_wr_en, wid_wr_en, rid_pre_full, wid_pre_full;
   logic          rd_done, wr_done, cnt_err;

   typedef struct packed {
      logic           wr;
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [LW-1:0]  len;
   } txn_t;

   txn_t exp_q[$];
   txn_t cmd_q[$];
   txn_t mon_t;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   rpc2_ctrl_cmd_arb #(
      .ID_WIDTH(IDW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .MAX_OUTST(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len),
      .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .rid_wr_en(rid_wr_en), .wid_wr_en(wid_wr_en), .id_wr_data(id_wr_data),
      .rid_pre_full(rid_pre_full), .wid_pre_full(wid_pre_full),
      .rd_done(rd_done), .wr_done(wr_done), .cnt_err(cnt_err)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic wr, input logic [IDW-1:0] id,
                       input logic [AW-1:0] addr, input logic [LW-1:0] len);
      txn_t t;
      t.wr = wr; t.id = id; t.addr = addr; t.len = len;
      exp_q.push_back(t);
   endtask

   // Called at posedge+1; holds the done pulses for exactly one cycle.
   task automatic pulse_done(input logic r, input logic w);
      rd_done = r;
      wr_done = w;
      adv();
      rd_done = 1'b0;
      wr_done = 1'b0;
   endtask

   task automatic set_ar(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      ar_id = id; ar_addr = addr; ar_len = len;
   endtask

   task automatic set_aw(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
      aw_id = id; aw_addr = addr; aw_len = len;
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (rid_wr_en || wid_wr_en) begin
            if (exp_q.size() == 0) begin
               check("unexpected_grant", {rid_wr_en, wid_wr_en}, 2'b00);
            end else begin
               mon_t = exp_q.pop_front();
               check("grant_dir", {rid_wr_en, wid_wr_en}, mon_t.wr ? 2'b01 : 2'b10);
               check("grant_ready", {ar_ready, aw_ready}, mon_t.wr ? 2'b01 : 2'b10);
               check("grant_id", id_wr_data, mon_t.id);
               cmd_q.push_back(mon_t);
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_q.size() == 0) begin
               check("unexpected_cmd", cmd_valid, 1'b0);
            end else begin
               mon_t = cmd_q.pop_front();
               check("cmd_fields", {cmd_write, cmd_addr, cmd_len}, {mon_t.wr, mon_t.addr, mon_t.len});
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      ar_valid = 1'b0; aw_valid = 1'b0; cmd_ready = 1'b0;
      rid_pre_full = 1'b0; wid_pre_full = 1'b0;
      rd_done = 1'b0; wr_done = 1'b0;
      set_ar('0, '0, '0);
      set_aw('0, '0, '0);

      repeat (2) @(posedge clk);
      smp();
      check("rst_ready", {ar_ready, aw_ready, rid_wr_en, wid_wr_en}, 4'h0);
      check("rst_cmd", {cmd_valid, cmd_write, cmd_addr, cmd_len}, '0);
      check("rst_id", id_wr_data, '0);
      check("rst_err", cnt_err, 1'b0);

      // Release with a read pending: INIT cycle, then grant, then ISSUE.
      adv();
      ar_valid = 1'b1;
      set_ar(4'h5, 32'h0000_1000, 8'h03);
      push(1'b0, 4'h5, 32'h0000_1000, 8'h03);
      rst_n = 1'b1;
      smp();
      check("init_ar_ready", ar_ready, 1'b0);
      adv();
      smp();
      check("a_ar_ready", ar_ready, 1'b1);
      check("a_rid_wr_en", {rid_wr_en, wid_wr_en}, 2'b10);
      check("a_id", id_wr_data, 4'h5);
      adv();
      ar_valid = 1'b0;
      aw_valid = 1'b1;
      set_aw(4'h9, 32'h0000_1100, 8'h10);
      push(1'b1, 4'h9, 32'h0000_1100, 8'h10);
      for (int i = 0; i < 5; i++) begin
         smp();
         check("a_hold_valid", cmd_valid, 1'b1);
         check("a_hold_fields", {cmd_write, cmd_addr, cmd_len}, {1'b0, 32'h0000_1000, 8'h03});
         check("a_hold_no_ready", {ar_ready, aw_ready}, 2'b00);
         adv();
      end
      cmd_ready = 1'b1;
      smp();
      check("a_accept_valid", cmd_valid, 1'b1);
      adv();
      smp();
      check("a_w_grant", {ar_ready, aw_ready}, 2'b01);
      adv();
      aw_valid = 1'b0;
      smp();
      check("a_w_issue", {cmd_valid, cmd_write}, 2'b11);
      adv();
      pulse_done(1'b1, 1'b1);
      smp();
      check("a_no_err", cnt_err, 1'b0);

      // Both requesting continuously: R,W,R,W two cycles apart, then saturation.
      adv();
      ar_valid = 1'b1;
      aw_valid = 1'b1;
      set_ar(4'hA, 32'h0000_2000, 8'h01);
      set_aw(4'h3, 32'h0000_3000, 8'h07);
      push(1'b0, 4'hA, 32'h0000_2000, 8'h01);
      push(1'b1, 4'h3, 32'h0000_3000, 8'h07);
      push(1'b0, 4'hA, 32'h0000_2000, 8'h01);
      push(1'b1, 4'h3, 32'h0000_3000, 8'h07);
      for (int c = 0; c < 10; c++) begin
         smp();
         check("b_rid_wr_en", rid_wr_en, (c == 0 || c == 4));
         check("b_wid_wr_en", wid_wr_en, (c == 2 || c == 6));
         adv();
      end

      // Saturation: writes free up independently of reads.
      wr_done = 1'b1;
      push(1'b1, 4'h3, 32'h0000_3000, 8'h07);
      smp();
      check("c_sat_no_grant", {ar_ready, aw_ready}, 2'b00);
      adv();
      wr_done = 1'b0;
      smp();
      check("c_w_after_done", {ar_ready, aw_ready}, 2'b01);
      adv();
      smp();
      adv();
      smp();
      check("c_both_sat", {ar_ready, aw_ready}, 2'b00);
      adv();
      rd_done = 1'b1;
      smp();
      check("c_sat_during_done", ar_ready, 1'b0);
      adv();
      set_ar(4'h7, 32'h0000_4000, 8'h02);
      push(1'b0, 4'h7, 32'h0000_4000, 8'h02);
      smp();
      check("c_r_grant_with_done", {ar_ready, aw_ready}, 2'b10);
      adv();
      rd_done = 1'b0;
      push(1'b0, 4'h7, 32'h0000_4000, 8'h02);
      smp();
      adv();
      smp();
      check("c_r_after_simul", ar_ready, 1'b1);
      adv();
      smp();
      adv();
      smp();
      check("c_r_sat_again", ar_ready, 1'b0);
      adv();
      ar_valid = 1'b0;
      aw_valid = 1'b0;
      pulse_done(1'b1, 1'b1);
      pulse_done(1'b1, 1'b1);

      // Read FIFO back-pressure blocks reads only.
      ar_valid = 1'b1;
      rid_pre_full = 1'b1;
      set_ar(4'hB, 32'h0000_5000, 8'h04);
      push(1'b0, 4'hB, 32'h0000_5000, 8'h04);
      smp();
      check("d_r_grant", ar_ready, 1'b1);
      adv();
      smp();
      adv();
      aw_valid = 1'b1;
      set_aw(4'hC, 32'h0000_6000, 8'h05);
      push(1'b1, 4'hC, 32'h0000_6000, 8'h05);
      smp();
      check("d_w_while_rfull", {ar_ready, aw_ready}, 2'b01);
      adv();
      aw_valid = 1'b0;
      smp();
      adv();
      smp();
      check("d_r_blocked", ar_ready, 1'b0);
      adv();
      smp();
      check("d_r_blocked2", ar_ready, 1'b0);
      adv();
      rid_pre_full = 1'b0;
      smp();
      check("d_r_blocked_last", ar_ready, 1'b0);
      adv();
      push(1'b0, 4'hB, 32'h0000_5000, 8'h04);
      smp();
      check("d_r_after_clear", ar_ready, 1'b1);
      adv();
      ar_valid = 1'b0;
      smp();
      adv();
      pulse_done(1'b1, 1'b1);
      pulse_done(1'b1, 1'b0);
      smp();
      check("d_no_err", cnt_err, 1'b0);

      // Underflow: error flag sets, counter stays at 0 (two reads still fit).
      adv();
      rd_done = 1'b1;
      adv();
      rd_done = 1'b0;
      smp();
      check("e_cnt_err", cnt_err, 1'b1);
      adv();
      ar_valid = 1'b1;
      set_ar(4'hD, 32'h0000_7000, 8'h06);
      push(1'b0, 4'hD, 32'h0000_7000, 8'h06);
      push(1'b0, 4'hD, 32'h0000_7000, 8'h06);
      for (int c = 0; c < 6; c++) begin
         smp();
         check("e_rid_wr_en", rid_wr_en, (c == 0 || c == 2));
         adv();
      end
      ar_valid = 1'b0;
      smp();
      check("e_err_sticky", cnt_err, 1'b1);
      check("queues_empty", exp_q.size() + cmd_q.size(), 0);

      // Reset asserted while a command is held in ISSUE.
      adv();
      pulse_done(1'b1, 1'b0);
      ar_valid = 1'b1;
      cmd_ready = 1'b0;
      set_ar(4'h1, 32'h0000_8000, 8'h09);
      push(1'b0, 4'h1, 32'h0000_8000, 8'h09);
      smp();
      check("f_r_grant", ar_ready, 1'b1);
      adv();
      ar_valid = 1'b0;
      smp();
      check("f_issue", {cmd_valid, cmd_addr}, {1'b1, 32'h0000_8000});
      #2;
      rst_n = 1'b0;
      #1;
      check("f_rst_ready", {ar_ready, aw_ready, rid_wr_en, wid_wr_en}, 4'h0);
      check("f_rst_cmd", {cmd_valid, cmd_write, cmd_addr, cmd_len}, '0);
      check("f_rst_id", id_wr_data, '0);
      check("f_rst_err", cnt_err, 1'b0);
      cmd_q.delete();

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
